// File: rtl/gen_scheduler.sv
// gen_scheduler: paces life_logic generation passes and edits, owns the display bank select; `WATCHDOG_EN adds a RUN-time abort.
module gen_scheduler #(
  parameter int LOG_MAX_SPEED = 3,
  parameter int LOG_BOARD_SIZE = 9,
  parameter int GEN_CNT_W = 16,
  parameter int WATCHDOG_CYCLES = 1048576
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      vsync_in,
  input  logic [LOG_MAX_SPEED-1:0]  speed_in,
  input  logic                      step_in,
  input  logic [LOG_BOARD_SIZE-1:0] cursor_x_in,
  input  logic [LOG_BOARD_SIZE-1:0] cursor_y_in,
  input  logic                      cursor_click_in,
  input  logic                      done_in,
  output logic                      start_out,
  output logic                      update_out,
  output logic                      click_out,
  output logic [LOG_BOARD_SIZE-1:0] click_x_out,
  output logic [LOG_BOARD_SIZE-1:0] click_y_out,
  output logic                      buf_sel_out,
  output logic [GEN_CNT_W-1:0]      gen_count_out,
  output logic                      busy_out,
  output logic                      wdt_err_out
);
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, SWAP} state_t;
  localparam logic [LOG_MAX_SPEED-1:0] FRAME_MAX = '1;
  state_t state;
  logic [LOG_MAX_SPEED-1:0] frame_cnt, period_m1;
  logic [LOG_BOARD_SIZE-1:0] edit_x, edit_y;
  logic click_pending, run_first, upd_go, launch, done_ok, wdt_abort;
  always_comb begin
    period_m1 = FRAME_MAX - speed_in;
    upd_go = state == IDLE && (speed_in != '0 ? vsync_in && frame_cnt >= period_m1 : step_in);
    launch = upd_go || (state == IDLE && click_pending);
    done_ok = state == RUN && !run_first && done_in;
  end
`ifdef WATCHDOG_EN
  localparam int WDT_W = $clog2(WATCHDOG_CYCLES + 1);
  logic [WDT_W-1:0] wdt_cnt;
  assign wdt_abort = state == RUN && !done_ok && wdt_cnt == WDT_W'(WATCHDOG_CYCLES - 1);
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      wdt_cnt <= '0;
      wdt_err_out <= 1'b0;
    end else begin
      wdt_cnt <= state == RUN ? wdt_cnt + 1'b1 : '0;
      if (wdt_abort) wdt_err_out <= 1'b1;
    end
`else
  assign wdt_abort = 1'b0;
  assign wdt_err_out = 1'b0;
`endif
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state <= IDLE;
      frame_cnt <= '0;
      click_pending <= 1'b0;
      edit_x <= '0;
      edit_y <= '0;
      run_first <= 1'b0;
      start_out <= 1'b0;
      update_out <= 1'b0;
      click_out <= 1'b0;
      click_x_out <= '0;
      click_y_out <= '0;
      buf_sel_out <= 1'b0;
      gen_count_out <= '0;
      busy_out <= 1'b0;
    end else begin
      start_out <= launch;
      frame_cnt <= (speed_in == '0 || upd_go) ? '0 :
                   (vsync_in && frame_cnt != FRAME_MAX) ? frame_cnt + 1'b1 : frame_cnt;
      // a click arriving on the launch edge must survive for the next pass
      click_pending <= cursor_click_in || (click_pending && !launch);
      if (cursor_click_in) begin
        edit_x <= cursor_x_in;
        edit_y <= cursor_y_in;
      end
      case (state)
        IDLE: if (launch) begin
          state <= LAUNCH;
          busy_out <= 1'b1;
          update_out <= upd_go;
          click_out <= click_pending;
          click_x_out <= edit_x;
          click_y_out <= edit_y;
        end
        LAUNCH: begin
          state <= RUN;
          run_first <= 1'b1;
        end
        RUN: begin
          run_first <= 1'b0;
          if (done_ok) state <= SWAP;
          else if (wdt_abort) begin
            state <= IDLE;
            busy_out <= 1'b0;
            update_out <= 1'b0;
            click_out <= 1'b0;
            click_x_out <= '0;
            click_y_out <= '0;
          end
        end
        SWAP: if (vsync_in) begin
          state <= IDLE;
          busy_out <= 1'b0;
          buf_sel_out <= !buf_sel_out;
          gen_count_out <= gen_count_out + GEN_CNT_W'(update_out);
          update_out <= 1'b0;
          click_out <= 1'b0;
        end
      endcase
    end
endmodule

// File: doc/gen_scheduler.md
Name: gen_scheduler

Overview:
Sequences generation passes of the life datapath. Paces passes from the display frame pulse and speed setting. Supports single-step and cursor edits while paused, and owns the ping-pong board-bank select. Sits between the UI/VGA timing blocks and life_logic, driving its start/update/click inputs and consuming its done.

Parameters:
LOG_MAX_SPEED, 3, width of speed_in; MAX_SPEED = 2**LOG_MAX_SPEED
LOG_BOARD_SIZE, 9, width of cursor coordinates
GEN_CNT_W, 16, width of generation counter
WATCHDOG_CYCLES, 1048576, max cycles a pass may run before abort (WATCHDOG_EN only)

Ports:
clk_in  in  1  system clock
rst_in  in  1  reset, asynchronous, active-high
vsync_in  in  1  one-cycle pulse per display frame
speed_in  in  LOG_MAX_SPEED  0 = paused; else period = MAX_SPEED - speed_in frames
step_in  in  1  one-cycle pulse: request one generation (honoured only when paused)
cursor_x_in  in  LOG_BOARD_SIZE  cursor column
cursor_y_in  in  LOG_BOARD_SIZE  cursor row
cursor_click_in  in  1  one-cycle pulse: toggle cell under cursor
done_in  in  1  life_logic pass complete (level)
start_out  out  1  one-cycle pass-start pulse to life_logic
update_out  out  1  1 = compute next gen, 0 = copy board (edit-only pass); held for whole pass
click_out  out  1  apply edit this pass; held for whole pass
click_x_out  out  LOG_BOARD_SIZE  latched edit column
click_y_out  out  LOG_BOARD_SIZE  latched edit row
buf_sel_out  out  1  bank currently displayed/read; life_logic writes !buf_sel_out
gen_count_out  out  GEN_CNT_W  completed update passes, wraps
busy_out  out  1  high in LAUNCH/RUN/SWAP
wdt_err_out  out  1  sticky watchdog error

Behaviour:
- Reset (async): state IDLE; all outputs 0; frame_cnt 0; click_pending 0.
- frame_cnt: increments on every vsync_in in all states when speed_in != 0; saturates at MAX_SPEED-1. Forced to 0 while speed_in == 0. Cleared on entering LAUNCH with an update pass.
- click_pending: set on cursor_click_in, coordinates captured into edit regs at that cycle. A later click overwrites the earlier one. Cleared on entering LAUNCH. A click in the LAUNCH cycle itself stays pending for the next pass.
- IDLE: launch decision, priority order:
  1. speed_in != 0 and frame_cnt >= period-1 and vsync_in -> update pass.
  2. speed_in == 0 and step_in -> update pass.
  3. click_pending -> edit-only pass (update=0).
  - step_in with speed_in != 0 is ignored.
  - A pending click always rides along: click_out = click_pending at launch.
- LAUNCH (1 cycle): start_out=1; update_out, click_out, click_x/y_out latched and held until return to IDLE.
- RUN: done_in is ignored in the first cycle after LAUNCH (stale done). Thereafter done_in=1 -> SWAP.
- SWAP: waits for vsync_in (tear-free). On vsync: toggle buf_sel_out; gen_count_out += update_out; clear update_out/click_out; -> IDLE. That vsync also counts in frame_cnt, but no new launch happens in the same cycle.
- speed_in change mid-count: compared against the current value each vsync; no restart.
- Reset mid-pass: immediate return to IDLE; bank select to 0; pending edit lost.

Optional Feature:
WATCHDOG_EN:
- Defined: a RUN cycle counter aborts the pass after WATCHDOG_CYCLES without done_in. On abort: -> IDLE, no bank swap, gen_count unchanged, wdt_err_out set (clears only on reset), latched edit is discarded.
- Undefined: no counter; wdt_err_out tied 0; RUN waits indefinitely.

Test Plan:
1. speed_in=7 (LOG_MAX_SPEED=3), done_in returned 10 cycles after start -> one start_out per vsync-aligned period; buf_sel toggles every second frame; gen_count 0->4 after 8 frames.
2. speed_in=0, step_in pulse, done after 5 cycles -> exactly one update pass; buf_sel 0->1 at next vsync; gen_count=1; a second step_in while busy is ignored.
3. speed_in=0, click at (3,5) -> edit-only pass with update_out=0, click_out=1, click_x/y=3/5; gen_count unchanged; buf_sel toggles.
4. Click at (1,1) during RUN of an update pass -> current pass click_out=0; next pass (edit-only) carries (1,1).
5. done_in held high from before start -> ignored in the first cycle after LAUNCH; with done then dropped and re-raised, SWAP is entered only on the re-raised done.
6. WATCHDOG_EN, WATCHDOG_CYCLES=64, done_in never asserted -> abort 64 cycles into RUN; wdt_err_out=1; buf_sel unchanged; rst_in pulsed mid-RUN -> all outputs 0 in the same cycle.
